// File: rtl/wb_retire_arbiter_pkg.sv
// Shared types for the writeback retire arbiter: field typedefs, the per-source
// request record, the arbiter state encoding and small request helpers.
package wb_retire_arbiter_pkg;

    localparam int XLEN  = 32;
    localparam int IID_W = 8;

    typedef logic [XLEN-1:0]  Addr;
    typedef logic [31:0]      Inst;
    typedef logic [IID_W-1:0] IId;
    typedef logic [4:0]       UInt5;
    typedef logic [XLEN-1:0]  UIntX;

    typedef struct packed {
        Addr  pc;
        Inst  inst;
        IId   inst_id;
        logic rf_wen;
        UInt5 reg_addr;
        UIntX wdata;
    } wb_req_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } arb_state_e;

    function automatic wb_req_t unpack_req(input Addr pc, input Inst inst, input IId iid,
                                           input logic rf_wen, input UInt5 reg_addr,
                                           input UIntX wdata);
        wb_req_t r;
        r.pc       = pc;
        r.inst     = inst;
        r.inst_id  = iid;
        r.rf_wen   = rf_wen;
        r.reg_addr = reg_addr;
        r.wdata    = wdata;
        return r;
    endfunction

    // x0 is hardwired to zero, so a write to it never reaches the register file
    function automatic logic eff_rf_wen(input wb_req_t r);
        return r.rf_wen & (r.reg_addr != 5'd0);
    endfunction

endpackage

// File: rtl/wb_retire_arbiter_prio_onehot_sel.sv
// Lowest-index one-hot picker with an any-request flag.
module prio_onehot_sel #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any
);

    logic seen_s;

    // Walk upward; the first set bit wins and masks all higher bits
    always_comb begin
        grant  = '0;
        seen_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            grant[i] = req[i] & ~seen_s;
            seen_s   = seen_s | req[i];
        end
    end

    assign any = |req;

endmodule

// File: rtl/wb_retire_arbiter.sv
// Arbitrates N_REQ completion sources onto the single writeback port, retiring
// strictly in instruction-id order and flagging stalls and duplicate ids.
module wb_retire_arbiter #(
    parameter int N_REQ       = 3,
    parameter int XLEN        = 32,
    parameter int IID_W       = 8,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [IID_W-1:0]       flush_id,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*XLEN-1:0]  req_pc,
    input  logic [N_REQ*32-1:0]    req_inst,
    input  logic [N_REQ*IID_W-1:0] req_inst_id,
    input  logic [N_REQ-1:0]       req_rf_wen,
    input  logic [N_REQ*5-1:0]     req_reg_addr,
    input  logic [N_REQ*XLEN-1:0]  req_wdata,
    output logic                   wb_valid,
    output logic [XLEN-1:0]        wb_pc,
    output logic [31:0]            wb_inst,
    output logic [IID_W-1:0]       wb_inst_id,
    output logic                   wb_rf_wen,
    output logic [4:0]             wb_reg_addr,
    output logic [XLEN-1:0]        wb_wdata,
    output logic [IID_W-1:0]       expected_id,
    output logic [31:0]            retire_count,
    output logic                   stall_err,
    output logic                   dup_err
);
    import wb_retire_arbiter_pkg::*;

    localparam int CW = $clog2(STALL_LIMIT + 1);

    arb_state_e       state_r, state_nxt_s;
    wb_req_t          req_s [N_REQ];
    wb_req_t          sel_s;
    logic [N_REQ-1:0] match_s, pick_s, grant_s;
    logic             match_any_s, arb_en_s, grant_any_s, dup_s, stall_inc_s;
    logic [IID_W-1:0] expected_id_r;
    logic [31:0]      retire_count_r;
    logic [CW-1:0]    stall_cnt_r;

    for (genvar i = 0; i < N_REQ; i++) begin : g_src
        assign req_s[i] = unpack_req(req_pc[i*XLEN +: XLEN], req_inst[i*32 +: 32],
                                     req_inst_id[i*IID_W +: IID_W], req_rf_wen[i],
                                     req_reg_addr[i*5 +: 5], req_wdata[i*XLEN +: XLEN]);
        assign match_s[i] = req_valid[i] & (req_s[i].inst_id == expected_id_r);
    end

    prio_onehot_sel #(.N(N_REQ)) u_sel (
        .req   (match_s),
        .grant (pick_s),
        .any   (match_any_s)
    );

    // Nothing retires during a flush or the drain cycle that follows it
    assign arb_en_s    = ~flush & (state_r == ST_RUN);
    assign grant_s     = arb_en_s ? pick_s : '0;
    assign grant_any_s = arb_en_s & match_any_s;
    assign req_ready   = grant_s;
    assign dup_s       = |(match_s & (match_s - N_REQ'(1)));
    assign stall_inc_s = ~flush & ~grant_any_s & (|req_valid);

    // One-hot AND-OR mux of the granted source's record
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_s = sel_s | ({$bits(wb_req_t){grant_s[i]}} & req_s[i]);
        end
    end

    // Next-state: any flush (re)enters DRAIN, otherwise return to RUN
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN:   state_nxt_s = flush ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt_s = flush ? ST_DRAIN : ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Writeback registers, retire tracking, stall counter and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid       <= 1'b0;
            wb_rf_wen      <= 1'b0;
            wb_pc          <= '0;
            wb_inst        <= 32'd0;
            wb_inst_id     <= '0;
            wb_reg_addr    <= 5'd0;
            wb_wdata       <= '0;
            expected_id_r  <= '0;
            retire_count_r <= 32'd0;
            stall_cnt_r    <= '0;
            stall_err      <= 1'b0;
            dup_err        <= 1'b0;
        end else if (flush) begin
            wb_valid      <= 1'b0;
            wb_rf_wen     <= 1'b0;
            expected_id_r <= flush_id;
            stall_cnt_r   <= '0;
        end else begin
            if (dup_s) begin
                dup_err <= 1'b1;
            end
            if (grant_any_s) begin
                wb_valid       <= 1'b1;
                wb_rf_wen      <= eff_rf_wen(sel_s);
                wb_pc          <= sel_s.pc;
                wb_inst        <= sel_s.inst;
                wb_inst_id     <= sel_s.inst_id;
                wb_reg_addr    <= sel_s.reg_addr;
                wb_wdata       <= sel_s.wdata;
                expected_id_r  <= expected_id_r + IID_W'(1);
                retire_count_r <= retire_count_r + 32'd1;
                stall_cnt_r    <= '0;
            end else begin
                wb_valid  <= 1'b0;
                wb_rf_wen <= 1'b0;
                if (stall_inc_s && (stall_cnt_r != CW'(STALL_LIMIT))) begin
                    stall_cnt_r <= stall_cnt_r + CW'(1);
                    if (stall_cnt_r == CW'(STALL_LIMIT - 1)) begin
                        stall_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign expected_id  = expected_id_r;
    assign retire_count = retire_count_r;

endmodule

// File: tb/tb_wb_retire_arbiter.sv
// Self-checking bench for wb_retire_arbiter: vector table, directed corner
// sequences and a randomized run against a rule-level reference model.
module tb_wb_retire_arbiter;

    localparam int N   = 3;
    localparam int LIM = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [7:0]      flush_id = 8'd0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_pc, req_inst, req_wdata;
    logic [N*8-1:0]  req_inst_id;
    logic [N-1:0]    req_rf_wen;
    logic [N*5-1:0]  req_reg_addr;
    logic            wb_valid, wb_rf_wen, stall_err, dup_err;
    logic [31:0]     wb_pc, wb_inst, wb_wdata, retire_count;
    logic [7:0]      wb_inst_id, expected_id;
    logic [4:0]      wb_reg_addr;

    logic [31:0] s_pc [N];
    logic [31:0] s_inst [N];
    logic [31:0] s_wdata [N];
    logic [7:0]  s_id [N];
    logic [4:0]  s_addr [N];
    logic        s_wen [N];

    for (genvar i = 0; i < N; i++) begin : g_bus
        assign req_pc[i*32 +: 32]      = s_pc[i];
        assign req_inst[i*32 +: 32]    = s_inst[i];
        assign req_wdata[i*32 +: 32]   = s_wdata[i];
        assign req_inst_id[i*8 +: 8]   = s_id[i];
        assign req_reg_addr[i*5 +: 5]  = s_addr[i];
        assign req_rf_wen[i]           = s_wen[i];
    end

    wb_retire_arbiter #(.N_REQ(N), .XLEN(32), .IID_W(8), .STALL_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_id(flush_id),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .req_inst(req_inst), .req_inst_id(req_inst_id), .req_rf_wen(req_rf_wen),
        .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_inst_id(wb_inst_id),
        .wb_rf_wen(wb_rf_wen), .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata),
        .expected_id(expected_id), .retire_count(retire_count),
        .stall_err(stall_err), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] rdy_pre;

    // reference model state
    logic [7:0]  m_exp;
    logic [31:0] m_cnt, m_pc, m_inst, m_wdata;
    logic [7:0]  m_iid;
    logic [4:0]  m_addr;
    logic        m_wbv, m_wen, m_serr, m_derr, m_drain;
    int          m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_exp = 8'd0; m_cnt = 32'd0; m_pc = 32'd0; m_inst = 32'd0; m_wdata = 32'd0;
        m_iid = 8'd0; m_addr = 5'd0; m_wbv = 1'b0; m_wen = 1'b0; m_serr = 1'b0;
        m_derr = 1'b0; m_drain = 1'b0; m_stall = 0;
    endtask

    // the first valid source holding the expected id, or -1
    function automatic int model_winner();
        if (flush || m_drain) return -1;
        for (int i = 0; i < N; i++) if (req_valid[i] && s_id[i] == m_exp) return i;
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        int nm;
        g = model_winner();
        nm = 0;
        for (int i = 0; i < N; i++) if (req_valid[i] && s_id[i] == m_exp) nm++;
        if (flush) begin
            m_exp = flush_id; m_wbv = 1'b0; m_wen = 1'b0; m_stall = 0; m_drain = 1'b1;
        end else begin
            if (nm > 1) m_derr = 1'b1;
            if (g >= 0) begin
                m_wbv = 1'b1; m_wen = s_wen[g] && (s_addr[g] != 5'd0);
                m_pc = s_pc[g]; m_inst = s_inst[g]; m_iid = s_id[g];
                m_addr = s_addr[g]; m_wdata = s_wdata[g];
                m_exp = m_exp + 8'd1; m_cnt = m_cnt + 32'd1; m_stall = 0;
            end else begin
                m_wbv = 1'b0; m_wen = 1'b0;
                if (req_valid != '0 && m_stall < LIM) begin
                    m_stall++;
                    if (m_stall == LIM) m_serr = 1'b1;
                end
            end
            m_drain = 1'b0;
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [7:0] id, input logic w,
                           input logic [4:0] a, input logic [31:0] d);
        req_valid[i] = v; s_id[i] = id; s_wen[i] = w; s_addr[i] = a; s_wdata[i] = d;
        s_pc[i] = 32'h0000_1000 + {22'd0, id, 2'b00};
        s_inst[i] = {id, 24'h000013};
    endtask

    task automatic set_std(input int i, input logic v, input logic [7:0] id);
        set_src(i, v, id, 1'b1, id[4:0], {24'hC0DE00, id});
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) set_src(i, 1'b0, 8'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // one clock: check grant before the edge, then all outputs against the model
    task automatic cycle();
        int g;
        logic [N-1:0] er;
        #1;
        g = model_winner();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        rdy_pre = req_ready;
        chk("req_ready", req_ready, er);
        @(posedge clk);
        model_edge();
        #1;
        chk("wb_valid", wb_valid, m_wbv);
        chk("wb_rf_wen", wb_rf_wen, m_wen);
        chk("expected_id", expected_id, m_exp);
        chk("retire_count", retire_count, m_cnt);
        chk("stall_err", stall_err, m_serr);
        chk("dup_err", dup_err, m_derr);
        chk("wb_pc", wb_pc, m_pc);
        chk("wb_inst", wb_inst, m_inst);
        chk("wb_inst_id", wb_inst_id, m_iid);
        chk("wb_reg_addr", wb_reg_addr, m_addr);
        chk("wb_wdata", wb_wdata, m_wdata);
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_wb_valid"}, wb_valid, 32'd0);
        chk({tag, "_wb_rf_wen"}, wb_rf_wen, 32'd0);
        chk({tag, "_wb_wdata"}, wb_wdata, 32'd0);
        chk({tag, "_wb_pc"}, wb_pc, 32'd0);
        chk({tag, "_expected_id"}, expected_id, 32'd0);
        chk({tag, "_retire_count"}, retire_count, 32'd0);
        chk({tag, "_stall_err"}, stall_err, 32'd0);
        chk({tag, "_dup_err"}, dup_err, 32'd0);
    endtask

    task automatic do_reset();
        clear_srcs();
        flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_outputs_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic flush_to(input logic [7:0] id);
        flush = 1'b1; flush_id = id;
        cycle();
        flush = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic [2:0] v;
        logic [7:0] id0, id1, id2;
        logic       fl;
        logic [7:0] fid;
        logic [2:0] e_rdy;
        logic       e_wbv;
        logic       e_wen;
        logic [7:0] e_eid;
    } vec_t;

    vec_t tbl [10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        tbl[0] = '{3'b001, 8'd0,  8'd0, 8'd0,    1'b0, 8'h00, 3'b001, 1'b1, 1'b0, 8'd1};
        tbl[1] = '{3'b001, 8'd1,  8'd0, 8'd0,    1'b0, 8'h00, 3'b001, 1'b1, 1'b1, 8'd2};
        tbl[2] = '{3'b001, 8'd2,  8'd0, 8'd0,    1'b0, 8'h00, 3'b001, 1'b1, 1'b1, 8'd3};
        tbl[3] = '{3'b010, 8'd0,  8'd4, 8'd0,    1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'd3};
        tbl[4] = '{3'b011, 8'd3,  8'd4, 8'd0,    1'b0, 8'h00, 3'b001, 1'b1, 1'b1, 8'd4};
        tbl[5] = '{3'b010, 8'd0,  8'd4, 8'd0,    1'b0, 8'h00, 3'b010, 1'b1, 1'b1, 8'd5};
        tbl[6] = '{3'b100, 8'd0,  8'd0, 8'd5,    1'b1, 8'h40, 3'b000, 1'b0, 1'b0, 8'h40};
        tbl[7] = '{3'b100, 8'd0,  8'd0, 8'h40,   1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'h40};
        tbl[8] = '{3'b100, 8'd0,  8'd0, 8'h40,   1'b0, 8'h00, 3'b100, 1'b1, 1'b0, 8'h41};
        tbl[9] = '{3'b000, 8'd0,  8'd0, 8'd0,    1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'h41};

        clear_srcs();
        model_reset();
        #2;
        do_reset();

        for (int r = 0; r < 10; r++) begin
            set_std(0, tbl[r].v[0], tbl[r].id0);
            set_std(1, tbl[r].v[1], tbl[r].id1);
            set_std(2, tbl[r].v[2], tbl[r].id2);
            flush = tbl[r].fl; flush_id = tbl[r].fid;
            cycle();
            chk($sformatf("tbl%0d_ready", r), rdy_pre, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_wb_valid", r), wb_valid, tbl[r].e_wbv);
            chk($sformatf("tbl%0d_wb_rf_wen", r), wb_rf_wen, tbl[r].e_wen);
            chk($sformatf("tbl%0d_expected_id", r), expected_id, tbl[r].e_eid);
        end
        flush = 1'b0;
        chk("tbl_retire_count", retire_count, 32'd6);

        // id wrap 255 -> 0
        do_reset();
        flush_to(8'd255);
        set_std(0, 1'b1, 8'd255);
        cycle();
        chk("wrap_iid255", wb_inst_id, 32'd255);
        chk("wrap_exp0", expected_id, 32'd0);
        set_std(0, 1'b1, 8'd0);
        cycle();
        chk("wrap_valid", wb_valid, 32'd1);
        chk("wrap_iid0", wb_inst_id, 32'd0);
        chk("wrap_exp1", expected_id, 32'd1);

        // write to x0 is suppressed but still retires
        set_src(0, 1'b1, 8'd1, 1'b1, 5'd0, 32'hDEADBEEF);
        cycle();
        chk("x0_valid", wb_valid, 32'd1);
        chk("x0_wen", wb_rf_wen, 32'd0);
        chk("x0_wdata", wb_wdata, 32'hDEADBEEF);

        // duplicate id 7 on sources 0 and 1
        clear_srcs();
        flush_to(8'd7);
        set_std(0, 1'b1, 8'd7);
        set_std(1, 1'b1, 8'd7);
        cycle();
        chk("dup_ready", rdy_pre, 32'b001);
        chk("dup_err", dup_err, 32'd1);
        set_std(0, 1'b0, 8'd0);
        cycle();
        chk("dup_src1_wait", rdy_pre, 32'b000);
        chk("dup_sticky", dup_err, 32'd1);

        // stall: hold id 9 while 8 is expected
        do_reset();
        flush_to(8'd8);
        set_std(1, 1'b1, 8'd9);
        repeat (3) cycle();
        chk("stall_before", stall_err, 32'd0);
        cycle();
        chk("stall_after4", stall_err, 32'd1);
        set_std(0, 1'b1, 8'd8);
        cycle();
        chk("stall_retire8", wb_inst_id, 32'd8);
        chk("stall_sticky", stall_err, 32'd1);

        // asynchronous reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs_zero("async");
        model_reset();
        clear_srcs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized in-order issue to random sources, with occasional flushes
        nxt = 0;
        for (int c = 0; c < 1500; c++) begin
            flush = 1'b0;
            for (int i = 0; i < N; i++) if (req_valid[i] && rdy_pre[i]) req_valid[i] = 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                flush = 1'b1;
                flush_id = 8'($urandom);
                clear_srcs();
                nxt = int'(flush_id);
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                        set_src(i, 1'b1, 8'(nxt), 1'($urandom), 5'($urandom), $urandom);
                        s_pc[i] = $urandom;
                        s_inst[i] = $urandom;
                        nxt = (nxt + 1) % 256;
                    end
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_retire_arbiter.md
Name: wb_retire_arbiter

Overview:
- Shares the single register-file write port (writeback stage) between N_REQ completion sources, e.g. ALU pipe, load/store unit and mul/div unit.
- Enforces in-order retirement by instruction id.
- Drives registered writeback signals straight into the writeback stage.
- Detects retirement stalls and duplicate ids.

Parameters:
- N_REQ, 3, number of completion sources; index 0 has the highest fixed priority on conflict.
- XLEN, 32, data/address width.
- IID_W, 8, instruction-id width; ids wrap modulo 2^IID_W.
- STALL_LIMIT, 1024, consecutive no-retire cycles while any request is pending before stall_err is set.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush
- flush_id  in  IID_W  id of the first instruction after a flush
- req_valid  in  N_REQ  source i has a completed instruction
- req_ready  out  N_REQ  source i accepted this cycle (combinational grant)
- req_pc  in  N_REQ*XLEN  per-source pc, packed, source i at [i*XLEN +: XLEN]
- req_inst  in  N_REQ*32  per-source instruction word
- req_inst_id  in  N_REQ*IID_W  per-source instruction id
- req_rf_wen  in  N_REQ  per-source register write enable
- req_reg_addr  in  N_REQ*5  per-source destination register
- req_wdata  in  N_REQ*XLEN  per-source write data
- wb_valid  out  1  registered retire strobe to the writeback stage
- wb_pc  out  XLEN  registered pc
- wb_inst  out  32  registered instruction word
- wb_inst_id  out  IID_W  registered id
- wb_rf_wen  out  1  registered write enable
- wb_reg_addr  out  5  registered destination register
- wb_wdata  out  XLEN  registered write data
- expected_id  out  IID_W  id allowed to retire next
- retire_count  out  32  total retired instructions
- stall_err  out  1  sticky: no retirement for STALL_LIMIT cycles while requests pending
- dup_err  out  1  sticky: more than one source presented expected_id in the same cycle

Behaviour:
- Reset (async, rst_n=0) clears:
  - wb_valid, wb_rf_wen and all wb_* data to 0.
  - expected_id=0, retire_count=0.
  - stall counter=0, stall_err=0, dup_err=0.
- Match: match[i] = req_valid[i] & (req_inst_id[i] == expected_id). Only the exact id may retire; other valid requests wait. Sources must hold their request stable until req_ready.
- Grant: one-hot, lowest-index set match bit. req_ready = grant, combinational in the same cycle. No grant when flush=1.
- Retire cycle (a grant exists and flush=0), at the next clk edge:
  - wb_* load the granted source's fields; wb_valid=1.
  - wb_rf_wen = req_rf_wen & (req_reg_addr != 0).
  - expected_id <= expected_id+1, wrapping from 2^IID_W-1 to 0.
  - retire_count +1; wraps at 2^32.
  - stall counter cleared.
- Idle cycle: wb_valid <= 0, wb_rf_wen <= 0. wb data holds its last value.
- Latency: exactly 1 cycle from grant to wb_valid. Throughput: 1 retire/cycle. The writeback stage never back-pressures.
- Duplicate: more than one match bit set → dup_err <= 1 (sticky). The lowest index is still granted; the others stay pending.
- Stall counter:
  - Increments on cycles with |req_valid, no grant and flush=0.
  - Saturates at STALL_LIMIT; stall_err <= 1 when it reaches STALL_LIMIT (sticky).
  - Clears on retire or flush.
- Flush (highest priority):
  - No grant that cycle.
  - Next edge: expected_id <= flush_id, wb_valid <= 0, wb_rf_wen <= 0, stall counter <= 0.
  - retire_count and the error flags are unchanged.
- Reset mid-operation: all state returns immediately to reset values; any pending grant is lost.
- State machine, two states:
  - RUN: normal operation.
  - DRAIN: entered on flush; stays one cycle with no grant; returns to RUN.
  - A flush while in DRAIN reloads expected_id and stays in DRAIN one more cycle.

Decomposition:
- Shared package: XLEN, IID_W, Addr, Inst, IId, UInt5 and UIntX typedefs; a wb_req_t struct {pc, inst, inst_id, rf_wen, reg_addr, wdata} with unpack helpers.
- One sub-module: prio_onehot_sel (parameterised lowest-index one-hot picker with an any-match output), reused elsewhere.

Test Plan:
- In-order single source: source 0 presents ids 0,1,2 back-to-back → wb_valid high 3 consecutive cycles, each 1 cycle after grant; expected_id=3; retire_count=3.
- Out-of-order arrival: source 1 holds id 1 while source 0 presents id 0 two cycles later → id 0 retires first, id 1 the next cycle; req_ready[1] low until then.
- x0 suppression: granted request with rf_wen=1, reg_addr=0, wdata=0xDEADBEEF → wb_valid=1, wb_rf_wen=0.
- Wrap: IID_W=8, expected_id=255, retire id 255 → expected_id=0; then id 0 retires.
- Flush: flush=1, flush_id=0x40 while source 2 holds id 5 → no grant, wb_valid=0 next cycle, expected_id=0x40; request id 0x40 then retires 2 cycles after flush.
- Errors:
  - Two sources both present id 7 when expected_id=7 → dup_err=1, source 0 granted.
  - With STALL_LIMIT=4, hold id 9 while expected_id=8 → stall_err=1 after the 4th stall cycle.
  - Async reset asserted mid-stream clears all outputs without a clock edge.
